// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction records into canonical 32-bit MIPS words and
// streams them into instruction memory at consecutive word addresses until HLT or full.
`ifndef INST_NOP
`define INST_NOP   6'd0
`define INST_ADDU  6'd1
`define INST_SUBU  6'd2
`define INST_SLT   6'd3
`define INST_ORI   6'd4
`define INST_LUI   6'd5
`define INST_LW    6'd6
`define INST_SW    6'd7
`define INST_BEQ   6'd8
`define INST_J     6'd9
`define INST_JAL   6'd10
`define INST_JR    6'd11
`define INST_JALR  6'd12
`define INST_ADDI  6'd13
`define INST_ADDIU 6'd14
`define INST_LB    6'd15
`define INST_SB    6'd16
`define INST_HLT   6'd17
`endif

`ifndef OPCODE_SPECIAL
`define OPCODE_SPECIAL 6'h00
`define OPCODE_J       6'h02
`define OPCODE_JAL     6'h03
`define OPCODE_BEQ     6'h04
`define OPCODE_ADDI    6'h08
`define OPCODE_ADDIU   6'h09
`define OPCODE_ORI     6'h0D
`define OPCODE_LUI     6'h0F
`define OPCODE_LB      6'h20
`define OPCODE_LW      6'h23
`define OPCODE_SB      6'h28
`define OPCODE_SW      6'h2B
`define OPCODE_HLT     6'h3F
`define FUNCT_JR       6'h08
`define FUNCT_JALR     6'h09
`define FUNCT_ADDU     6'h21
`define FUNCT_SUBU     6'h23
`define FUNCT_SLT      6'h2A
`endif

module inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_inst,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              illegal,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                ill_q, ill_d;
  logic                accept;
  logic [31:0]         enc_word;
  logic                enc_ill;
  logic                unused_shamt;

  // every supported format forces the shift field to zero
  assign unused_shamt = ^in_shamt;

  assign in_ready = (state_q == S_RUN) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_word = 32'h0;
    enc_ill  = 1'b0;
    case (in_inst)
      `INST_NOP:   enc_word = 32'h0;
      `INST_ADDU:  enc_word = {`OPCODE_SPECIAL, in_rs, in_rt, in_rd, 5'b0, `FUNCT_ADDU};
      `INST_SUBU:  enc_word = {`OPCODE_SPECIAL, in_rs, in_rt, in_rd, 5'b0, `FUNCT_SUBU};
      `INST_SLT:   enc_word = {`OPCODE_SPECIAL, in_rs, in_rt, in_rd, 5'b0, `FUNCT_SLT};
      `INST_JR:    enc_word = {`OPCODE_SPECIAL, in_rs, 10'b0, 5'b0, `FUNCT_JR};
      `INST_JALR:  enc_word = {`OPCODE_SPECIAL, in_rs, 5'b0, in_rd, 5'b0, `FUNCT_JALR};
      `INST_ORI:   enc_word = {`OPCODE_ORI,   in_rs, in_rt, in_imm};
      `INST_LW:    enc_word = {`OPCODE_LW,    in_rs, in_rt, in_imm};
      `INST_SW:    enc_word = {`OPCODE_SW,    in_rs, in_rt, in_imm};
      `INST_BEQ:   enc_word = {`OPCODE_BEQ,   in_rs, in_rt, in_imm};
      `INST_ADDI:  enc_word = {`OPCODE_ADDI,  in_rs, in_rt, in_imm};
      `INST_ADDIU: enc_word = {`OPCODE_ADDIU, in_rs, in_rt, in_imm};
      `INST_LB:    enc_word = {`OPCODE_LB,    in_rs, in_rt, in_imm};
      `INST_SB:    enc_word = {`OPCODE_SB,    in_rs, in_rt, in_imm};
      `INST_LUI:   enc_word = {`OPCODE_LUI,   5'b0,  in_rt, in_imm};
      `INST_J:     enc_word = {`OPCODE_J,     in_target};
      `INST_JAL:   enc_word = {`OPCODE_JAL,   in_target};
      `INST_HLT:   enc_word = {`OPCODE_HLT,   26'b0};
      default:     enc_ill  = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    we_d    = accept;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = S_RUN;
      addr_d  = base_addr;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
    end else if (accept) begin
      waddr_d = addr_q;
      wdata_d = enc_word;
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (enc_ill) ill_d = 1'b1;
      // HLT in the last slot is a clean finish, not an overflow
      if (in_inst == `INST_HLT) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else if (addr_q == {ADDR_W{1'b1}}) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign illegal    = ill_q;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed + random stimulus against a table-driven MIPS encoding model
// and a word decoder for round-trip checking of every memory write.
module tb_inst_encoder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam longint P11 = 64'd1 << 11;
  localparam longint P16 = 64'd1 << 16;
  localparam longint P21 = 64'd1 << 21;
  localparam longint P26 = 64'd1 << 26;

  localparam logic [5:0] C_NOP = 6'd0,  C_ADDU = 6'd1, C_SUBU = 6'd2,  C_SLT = 6'd3,
                         C_ORI = 6'd4,  C_LUI = 6'd5,  C_LW = 6'd6,    C_SW = 6'd7,
                         C_BEQ = 6'd8,  C_J = 6'd9,    C_JAL = 6'd10,  C_JR = 6'd11,
                         C_JALR = 6'd12, C_ADDI = 6'd13, C_ADDIU = 6'd14, C_LB = 6'd15,
                         C_SB = 6'd16,  C_HLT = 6'd17, C_BAD = 6'h3E;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [5:0]  in_inst = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_ready, imem_we, busy, done, overflow, illegal;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;

  inst_encoder #(.ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .overflow(overflow), .illegal(illegal), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // MIPS word from the record, built field by field with plain arithmetic
  function automatic logic [31:0] ref_word(input logic [5:0] c, input longint rs, input longint rt,
                                           input longint rd, input longint imm, input longint tgt,
                                           output bit ill);
    longint w;
    longint op;
    ill = 0; w = 0; op = -1;
    case (c)
      C_NOP:  w = 0;
      C_ADDU: w = rs*P21 + rt*P16 + rd*P11 + 'h21;
      C_SUBU: w = rs*P21 + rt*P16 + rd*P11 + 'h23;
      C_SLT:  w = rs*P21 + rt*P16 + rd*P11 + 'h2A;
      C_JR:   w = rs*P21 + 'h08;
      C_JALR: w = rs*P21 + rd*P11 + 'h09;
      C_ORI:  op = 'h0D;
      C_LW:   op = 'h23;
      C_SW:   op = 'h2B;
      C_BEQ:  op = 'h04;
      C_ADDI: op = 'h08;
      C_ADDIU: op = 'h09;
      C_LB:   op = 'h20;
      C_SB:   op = 'h28;
      C_LUI:  w = 'h0F*P26 + rt*P16 + imm;
      C_J:    w = 'h02*P26 + tgt;
      C_JAL:  w = 'h03*P26 + tgt;
      C_HLT:  w = 'h3F*P26;
      default: ill = 1;
    endcase
    if (op >= 0) w = op*P26 + rs*P21 + rt*P16 + imm;
    return w[31:0];
  endfunction

  function automatic logic [5:0] ref_decode(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26]; fn = w[5:0];
    if (w == 32'h0) return C_NOP;
    case (op)
      6'h00: case (fn)
               6'h21: return C_ADDU;
               6'h23: return C_SUBU;
               6'h2A: return C_SLT;
               6'h08: return C_JR;
               6'h09: return C_JALR;
               default: return C_BAD;
             endcase
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h08: return C_ADDI;
      6'h09: return C_ADDIU;
      6'h20: return C_LB;
      6'h28: return C_SB;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h3F: return C_HLT;
      default: return C_BAD;
    endcase
  endfunction

  // model state reflects the DUT after the coming rising edge
  bit m_run = 0, m_done = 0, m_ovf = 0, m_ill = 0;
  int m_addr = 0, m_cnt = 0;
  bit x_we = 0, x_ill = 0;
  int x_addr = 0;
  logic [31:0] x_data = '0;
  logic [5:0]  x_code = '0;
  logic [31:0] wr_mem [int];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        m_run = 0; m_done = 0; m_ovf = 0; m_ill = 0; m_addr = 0; m_cnt = 0; x_we = 0;
      end else begin
        chk("we", imem_we, x_we);
        if (imem_we) wr_mem[int'(imem_addr)] = imem_wdata;
        if (x_we && imem_we) begin
          chk("addr", imem_addr, x_addr);
          chk("wdata", imem_wdata, x_data);
          if (!x_ill) chk("decode", ref_decode(imem_wdata), x_code);
        end
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("illegal", illegal, m_ill);
        chk("count", count, m_cnt);
        chk("in_ready", in_ready, m_run && !start);
        x_we = 0;
        if (start) begin
          m_run = 1; m_addr = int'(base_addr); m_cnt = 0; m_done = 0; m_ovf = 0; m_ill = 0;
        end else if (m_run && in_valid) begin
          x_we = 1; x_addr = m_addr; x_code = in_inst;
          x_data = ref_word(in_inst, in_rs, in_rt, in_rd, in_imm, in_target, x_ill);
          if (x_ill) m_ill = 1;
          m_cnt++;
          if (in_inst == C_HLT) begin
            m_run = 0; m_done = 1;
          end else if (m_addr == DEPTH-1) begin
            m_run = 0; m_done = 1; m_ovf = 1;
          end
          m_addr = (m_addr + 1) % DEPTH;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int base);
    start = 1'b1; base_addr = base[AW-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] c, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tgt);
    in_valid = 1'b1; in_inst = c;
    in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0]; in_shamt = sh[4:0];
    in_imm = imm[15:0]; in_target = tgt[25:0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        return;
      end
      tick();
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_inst = 6'($urandom); in_rs = 5'($urandom); in_imm = 16'($urandom);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // reset
    tick(); tick();
    chk("reset_wdata", imem_wdata, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    tick();

    // single ADDU with shamt ignored
    do_start(0);
    send(C_ADDU, 1, 2, 3, 7, 0, 0);
    idle(2);
    chk("t1_word", wr_mem[0], 32'h00221821);

    // back-to-back stream ending with HLT
    wr_mem.delete();
    do_start(0);
    send(C_ORI, 0, 1, 0, 0, 'h1234, 0);
    send(C_LUI, 9, 5, 0, 0, 'hABCD, 0);
    send(C_J, 0, 0, 0, 0, 0, 'h100);
    send(C_HLT, 3, 4, 5, 6, 'hFFFF, 'h3FFFFFF);
    idle(2);
    chk("t2_w0", wr_mem[0], 32'h34011234);
    chk("t2_w1", wr_mem[1], 32'h3C05ABCD);
    chk("t2_w2", wr_mem[2], 32'h08000100);
    chk("t3_hlt", wr_mem[3], 32'hFC000000);
    chk("t3_done", done, 1);
    chk("t3_count", count, 4);
    chk("t3_ready", in_ready, 0);

    // fill the last two words; further beats must stall
    do_start(DEPTH-2);
    send(C_ADDIU, 1, 2, 0, 0, 5, 0);
    send(C_ADDIU, 3, 4, 0, 0, 6, 0);
    for (int i = 0; i < 4; i++) tick();
    idle(1);
    chk("t4_ovf", overflow, 1);
    chk("t4_done", done, 1);
    chk("t4_count", count, 2);

    // HLT landing on the last word is not an overflow
    do_start(DEPTH-1);
    send(C_HLT, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t4_hlt_last_ovf", overflow, 0);

    // undefined code
    wr_mem.delete();
    do_start(5);
    send(C_BAD, 7, 7, 7, 7, 'h7777, 'h777);
    idle(2);
    chk("t5_ill", illegal, 1);
    chk("t5_word", wr_mem[5], 32'h0);
    do_start(6);
    chk("t5_clear", illegal, 0);
    idle(1);

    // start wins over a same-cycle record
    in_valid = 1'b1; in_inst = C_ADDU; start = 1'b1; base_addr = 10'd20;
    tick();
    start = 1'b0; in_valid = 1'b0;
    idle(1);
    chk("t6_count", count, 0);

    // async reset while a write is in flight
    in_valid = 1'b1; in_inst = C_SUBU; in_rs = 5'd4;
    @(negedge clk);
    chk("t6_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", imem_we, 0);
    chk("t6_rst_wdata", imem_wdata, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // random legal records, checked by the negedge model
    do_start($urandom_range(0, 900));
    for (int n = 0; n < 1000; n++) begin
      logic [5:0] c;
      if (!m_run) do_start($urandom_range(0, DEPTH-1));
      c = ($urandom_range(0, 49) == 0) ? C_HLT : 6'($urandom_range(0, 16));
      send(c, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
